seg_scan: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds a double-buffered hex value and walks one digit at a time through the shared `seg` decoder. For each slot it presents the digit's nibble on `digit_data` and drives the matching active-low digit enable. A dead time at each slot start prevents ghosting, and optional leading-zero blanking is supported. It sits between the register/bus logic that supplies the value and the single `seg` decoder instance feeding the segment pins.

---
 rtl/seg_scan.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display. Holds a double-buffered hex value, walks one digit per
// slot with a dead time at each slot start, and optionally blanks leading
// zeros. Outputs are registered and decoded from next-state values.
module seg_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int DEAD   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [7:0]            digit_data,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // State registers
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    active_q, active_d;
    logic [4*DIGITS-1:0]    pend_q, pend_d;
    logic                   pending_q, pending_d;
    logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;
    logic [7:0]             digit_data_q, digit_data_d;
    logic                   frame_done_q, frame_done_d;

    logic                   tick;
    logic                   boundary;

    // Per-digit views of the next active value
    logic [3:0]             nib_d [DIGITS];
    logic [DIGITS-1:0]      upper_zero_d;   // nibbles gi..DIGITS-1 all zero
    logic [DIGITS-1:0]      blank_d;        // digit gi is a blanked leading zero
    logic [DIGITS-1:0]      sel_low_d;      // one-hot (active-high) of idx_d

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_d[gi] = active_d[4*gi +: 4];

            if (gi == DIGITS - 1) begin : g_top
                assign upper_zero_d[gi] = (nib_d[gi] == 4'h0);
            end else begin : g_mid
                assign upper_zero_d[gi] = (nib_d[gi] == 4'h0) && upper_zero_d[gi+1];
            end

            // The rightmost digit always shows, so a zero value still reads "0".
            if (gi == 0) begin : g_lsd
                assign blank_d[gi] = 1'b0;
            end else begin : g_hi
                assign blank_d[gi] = blank_lz && upper_zero_d[gi];
            end

            assign sel_low_d[gi] = (idx_d == IW'(gi));
        end
    endgenerate

    // Prescaler, digit index and double-buffer next-state
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (idx_q == IDX_LAST);

        cnt_d = tick ? '0 : cnt_q + CW'(1);

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        active_d  = active_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (load && boundary) begin
            // Freshest value goes straight to the display; stale pend is dropped.
            active_d  = value;
            pending_d = 1'b0;
        end else if (load) begin
            pend_d    = value;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            active_d  = pend_q;
            pending_d = 1'b0;
        end
    end

    // Output decode from next-state so registered outputs align with state
    always_comb begin
        logic in_dead;
        logic cur_blank;
        in_dead   = (cnt_d < CNT_DEAD);
        cur_blank = blank_d[idx_d];

        if (in_dead || cur_blank) begin
            dig_sel_d = '1;
        end else begin
            dig_sel_d = ~sel_low_d;
        end

        if (cur_blank) begin
            digit_data_d = 8'h10;
        end else begin
            digit_data_d = {4'h0, nib_d[idx_d]};
        end

        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            dig_sel_q    <= '1;
            digit_data_q <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            dig_sel_q    <= dig_sel_d;
            digit_data_q <= digit_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_data = digit_data_q;
    assign dig_sel    = dig_sel_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
